qam_mod_core: RTL and testbench
===============================

# qam_mod_core

Parametrised M-QAM baseband modulator core: sources a serial bit stream (internal PRBS or external serial input), packs 2·K bits per symbol into I and Q words, and maps each word to a signed odd-integer amplitude level. It generalises the fixed 16-QAM chain (m-sequence → serial-to-parallel → level transfer) to any square constellation. It adds source selection, valid/ready backpressure on the symbol output, and optional Gray mapping. It sits between the bit source and the pulse-shaping / DAC stage of the modulator.

## Interface
- BITS_PER_AXIS, 2: K, bits per axis; constellation is 4^K-QAM; legal range 1..6.
- PRBS_ORDER, 3: LFSR length N; legal range 3..15; taps from package.
- PRBS_SEED, 1: reset value of the LFSR; must be nonzero.
- clk  input  1  core clock; the only clock.
- rst  input  1  reset; asynchronous, active-low.
- en  input  1  run enable; when low, no bits are accepted and all state holds.
- src_sel  input  1  bit source: 0 = internal PRBS, 1 = external in_bit.
- in_bit  input  1  external serial bit.
- in_valid  input  1  in_bit valid.
- in_ready  output  1  external bit accepted this cycle when in_valid is also high.
- lfsr_state  output  N  current LFSR contents.
- sym_i  output  K+1  signed I level.
- sym_q  output  K+1  signed Q level.
- sym_valid  output  1  symbol held on sym_i/sym_q.
- sym_ready  input  1  downstream accepts the symbol.
- sym_cnt  output  16  count of symbols handed off; wraps modulo 2^16.

## Operation
- Reset values:
  - lfsr_state = PRBS_SEED.
  - sym_i = sym_q = 0.
  - sym_valid = 0, in_ready = 0, sym_cnt = 0.
  - Bit counter = 0; shifter = 0.
- out_free = !sym_valid || sym_ready.
- Bit accept condition: en && (bit_cnt != 2K-1 || out_free) && source bit available.
  - Source bit availability: with PRBS selected, always available; with external selected, in_valid must be high.
- in_ready = en && src_sel && (bit_cnt != 2K-1 || out_free); combinational.
- PRBS:
  - Fibonacci LFSR; output bit = lfsr_state[N-1].
  - Advances only on a cycle where a PRBS bit is accepted; it never advances while stalled or in external mode.
  - Period is 2^N-1.
- Packing:
  - Bits are accepted MSB-first.
  - The first K accepted bits form the I word; the next K form the Q word.
  - bit_cnt counts 0..2K-1 and then wraps to 0.
- On acceptance of bit 2K-1:
  - The symbol is mapped and loaded into the output register.
  - sym_valid is set.
- Handshake:
  - A symbol transfers when sym_valid && sym_ready; sym_cnt increments at that edge.
  - If a transfer and a new load coincide, the load wins: sym_valid stays 1 and the new values appear.
  - sym_i and sym_q are stable while sym_valid && !sym_ready.
- Mapping:
  - Let v be the K-bit index; level = 2·v − (2^K − 1), computed in K+1-bit two's complement.
  - For K=2, levels are −3, −1, +1, +3.
- Boundary conditions:
  - en falling mid-symbol: the partial word and bit_cnt hold, and packing resumes on the same bit position.
  - src_sel change mid-symbol: takes effect on the next accepted bit; bit_cnt is not cleared.
  - rst asserted mid-symbol or mid-handshake: all state returns to reset values immediately; the partial symbol is discarded.
  - Stall at bit 2K-1 with output blocked: the bit is not consumed and the PRBS does not advance.

## Timing
- One bit accepted per cycle at most; peak rate is one symbol per 2K cycles.
- Latency:
  - sym_valid rises on the edge that accepts bit 2K-1.
  - With en=1 and sym_ready=1 from the first edge after reset release, the first sym_valid is high after edge 2K, counting edges from 1.
- No output bubble at full rate: consecutive symbols are exactly 2K cycles apart.
- sym_cnt, lfsr_state, sym_i, sym_q and sym_valid are registered. in_ready is combinational from en, src_sel, bit_cnt, sym_valid and sym_ready.

## Configuration
- QAM_GRAY_EN defined: each K-bit word is treated as Gray code and converted to binary before level mapping. Adjacent levels then differ in one bit.
  - K=2 mapping: 00→−3, 01→−1, 11→+1, 10→+3.
- QAM_GRAY_EN undefined: natural binary mapping.
  - K=2 mapping: 00→−3, 01→−1, 10→+1, 11→+3.
- Handshake, latency and port list are identical in both builds.

## Structure
- Shared package qam_pkg contains:
  - the LFSR tap-mask constants/function indexed by order 3..15 (order 3 uses x^3+x^2+1);
  - the level-width function K+1;
  - the gray-to-binary function.
- Sub-module qam_prbs_gen, parameterised by PRBS_ORDER and PRBS_SEED, with an advance input, a bit output and a state output.
- Packing, mapping and the output register stay in qam_mod_core.

## Test plan
- Reset and free-run:
  - Stimulus: K=2, N=3, seed 1, PRBS, en=1, sym_ready=1.
  - Required: first sym_valid after edge 4; lfsr_state sequence repeats every 7 advances; a new symbol every 4 cycles; sym_cnt increments each symbol.
- External mapping:
  - Stimulus: src_sel=1, bits 1,0,1,1.
  - Required with QAM_GRAY_EN: sym_i=+3, sym_q=+1.
  - Required without QAM_GRAY_EN: sym_i=+1, sym_q=+3.
- Backpressure:
  - Stimulus: sym_ready=0 for 10 cycles.
  - Required: the held symbol stays stable; 3 bits are accepted, then the stall holds bit_cnt=3; lfsr_state frozen; in_ready=0 in external mode.
  - After sym_ready=1: transfer, immediate reload, and the next symbol 4 cycles later.
- en and in_valid gaps:
  - Stimulus: drop en after 2 bits for 5 cycles, and insert in_valid gaps.
  - Required: the resulting symbol equals the gap-free reference; no bits are lost or duplicated.
- Mid-operation reset:
  - Stimulus: assert rst with sym_valid=1 and bit_cnt=2.
  - Required: all outputs return to reset values asynchronously; after release, the first symbol again appears 4 cycles later.
- K=3 sweep:
  - Stimulus: all 8 I words via the external source.
  - Required: levels −7..+7 odd, in 4-bit two's complement, in the mapping selected by QAM_GRAY_EN.

Source files
------------

// File: rtl/qam_pkg.sv
// Shared definitions for the M-QAM modulator: LFSR tap masks, level width and Gray decode.
package qam_pkg;

    localparam int MAX_K = 6;
    localparam int MAX_N = 15;

    typedef enum logic {
        SRC_PRBS = 1'b0,
        SRC_EXT  = 1'b1
    } src_t;

    // Bit e-1 set for each term x^e of the feedback polynomial (maximal-length for every order).
    function automatic logic [MAX_N-1:0] lfsr_taps(input int order);
        logic [MAX_N-1:0] m;
        case (order)
            3:       m = 15'h0006;
            4:       m = 15'h000C;
            5:       m = 15'h0014;
            6:       m = 15'h0030;
            7:       m = 15'h0060;
            8:       m = 15'h00B8;
            9:       m = 15'h0110;
            10:      m = 15'h0240;
            11:      m = 15'h0500;
            12:      m = 15'h0829;
            13:      m = 15'h100D;
            14:      m = 15'h2015;
            15:      m = 15'h6000;
            default: m = 15'h0006;
        endcase
        return m;
    endfunction

    function automatic int level_width(input int k);
        return k + 1;
    endfunction

    function automatic logic [MAX_K-1:0] gray2bin(input logic [MAX_K-1:0] g);
        logic [MAX_K-1:0] b;
        b[MAX_K-1] = g[MAX_K-1];
        for (int i = MAX_K - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/qam_mod_core_if.sv
// Serial bit intake and symbol output handshake of the modulator core.
interface qam_mod_core_if
    import qam_pkg::*;
#(
    parameter int K = 2
);
    logic                          in_bit;
    logic                          in_valid;
    logic                          in_ready;
    logic signed [level_width(K)-1:0] sym_i;
    logic signed [level_width(K)-1:0] sym_q;
    logic                          sym_valid;
    logic                          sym_ready;

    // master is the core: it accepts bits and sources symbols.
    modport master (
        input  in_bit, in_valid, sym_ready,
        output in_ready, sym_i, sym_q, sym_valid
    );

    modport slave (
        output in_bit, in_valid, sym_ready,
        input  in_ready, sym_i, sym_q, sym_valid
    );
endinterface

// File: rtl/qam_prbs_gen.sv
// Fibonacci LFSR bit source; shifts only when advance is high, output bit is the MSB.
module qam_prbs_gen
    import qam_pkg::*;
#(
    parameter int PRBS_ORDER = 3,
    parameter int PRBS_SEED  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    output logic                  prbs_bit,
    output logic [PRBS_ORDER-1:0] state
);
    localparam logic [MAX_N-1:0]      TAPS_FULL = lfsr_taps(PRBS_ORDER);
    localparam logic [PRBS_ORDER-1:0] TAPS      = TAPS_FULL[PRBS_ORDER-1:0];
    localparam logic [PRBS_ORDER-1:0] SEED      = PRBS_ORDER'(PRBS_SEED);

    logic [PRBS_ORDER-1:0] state_q;
    logic [PRBS_ORDER-1:0] state_d;

    always_comb begin
        state_d = state_q;
        if (advance) begin
            state_d = {state_q[PRBS_ORDER-2:0], ^(state_q & TAPS)};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign prbs_bit = state_q[PRBS_ORDER-1];
    assign state    = state_q;

endmodule

// File: rtl/qam_mod_core.sv
// M-QAM modulator core: packs 2K source bits per symbol and maps each K-bit word to an odd level.
// Define QAM_GRAY_EN to treat each word as Gray code before level mapping.
module qam_mod_core
    import qam_pkg::*;
#(
    parameter int BITS_PER_AXIS = 2,
    parameter int PRBS_ORDER    = 3,
    parameter int PRBS_SEED     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  src_sel,
    qam_mod_core_if.master        bus,
    output logic [PRBS_ORDER-1:0] lfsr_state,
    output logic [15:0]           sym_cnt
);
    localparam int K  = BITS_PER_AXIS;
    localparam int W  = level_width(K);
    localparam int NB = 2 * K;
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] LAST      = CW'(NB - 1);
    localparam logic [W-1:0]  SIGN_FLIP = W'(1) << K;

    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [NB-1:0] shift_q, shift_d;
    logic [W-1:0]  sym_i_q, sym_i_d;
    logic [W-1:0]  sym_q_q, sym_q_d;
    logic          sym_valid_q, sym_valid_d;
    logic [15:0]   sym_cnt_q, sym_cnt_d;

    logic          prbs_bit;
    logic          prbs_adv;
    logic          src_bit;
    logic          src_avail;
    logic          at_last;
    logic          out_free;
    logic          slot_open;
    logic          accept;
    logic          xfer;
    logic [NB-1:0] word;
    src_t          src;

    // 2v - (2^K - 1) equals {v,1} with its top bit inverted in K+1-bit two's complement.
    function automatic logic [W-1:0] map_level(input logic [K-1:0] w);
        logic [K-1:0] v;
`ifdef QAM_GRAY_EN
        v = K'(gray2bin(MAX_K'(w)));
`else
        v = w;
`endif
        return {v, 1'b1} ^ SIGN_FLIP;
    endfunction

    qam_prbs_gen #(
        .PRBS_ORDER (PRBS_ORDER),
        .PRBS_SEED  (PRBS_SEED)
    ) u_prbs (
        .clk      (clk),
        .rst      (rst),
        .advance  (prbs_adv),
        .prbs_bit (prbs_bit),
        .state    (lfsr_state)
    );

    assign src = src_t'(src_sel);

    always_comb begin
        at_last   = (bit_cnt_q == LAST);
        out_free  = !sym_valid_q || bus.sym_ready;
        // The closing bit of a symbol is only taken when the output register can be reloaded.
        slot_open = en && (!at_last || out_free);
        src_avail = (src == SRC_EXT) ? bus.in_valid : 1'b1;
        src_bit   = (src == SRC_EXT) ? bus.in_bit : prbs_bit;
        accept    = slot_open && src_avail;
        prbs_adv  = accept && (src == SRC_PRBS);
        xfer      = sym_valid_q && bus.sym_ready;
        word      = {shift_q[NB-2:0], src_bit};

        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        sym_i_d     = sym_i_q;
        sym_q_d     = sym_q_q;
        sym_valid_d = sym_valid_q;
        sym_cnt_d   = sym_cnt_q;

        if (accept) begin
            shift_d   = word;
            bit_cnt_d = at_last ? '0 : bit_cnt_q + 1'b1;
        end

        // en gates bit intake only; an offered symbol still completes its handshake.
        if (xfer) begin
            sym_valid_d = 1'b0;
            sym_cnt_d   = sym_cnt_q + 16'd1;
        end

        if (accept && at_last) begin
            sym_valid_d = 1'b1;
            sym_i_d     = map_level(word[NB-1:K]);
            sym_q_d     = map_level(word[K-1:0]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            sym_i_q     <= '0;
            sym_q_q     <= '0;
            sym_valid_q <= 1'b0;
            sym_cnt_q   <= '0;
        end else begin
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            sym_i_q     <= sym_i_d;
            sym_q_q     <= sym_q_d;
            sym_valid_q <= sym_valid_d;
            sym_cnt_q   <= sym_cnt_d;
        end
    end

    assign bus.in_ready  = slot_open && (src == SRC_EXT);
    assign bus.sym_i     = sym_i_q;
    assign bus.sym_q     = sym_q_q;
    assign bus.sym_valid = sym_valid_q;
    assign sym_cnt       = sym_cnt_q;

endmodule

// File: tb/tb_qam_mod_core.sv
// Bench for qam_mod_core: bit-queue reference model checked every cycle plus literal anchor checks.
module tb_qam_mod_core;

`ifdef QAM_GRAY_EN
    localparam int GRAY = 1;
`else
    localparam int GRAY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        en0, src0, en1, src1;
    logic [2:0]  lfsr0;
    logic [3:0]  lfsr1;
    logic [15:0] cnt0, cnt1;

    int n_checks = 0;
    int n_fail   = 0;

    int seq [4096];
    int m_bits [$];
    int m_pidx, m_i, m_q, m_cnt;
    bit m_valid;
    int k3_lvl [8];

    always #5 clk = ~clk;

    qam_mod_core_if #(.K(2)) if0 ();
    qam_mod_core_if #(.K(3)) if1 ();

    qam_mod_core #(.BITS_PER_AXIS(2), .PRBS_ORDER(3), .PRBS_SEED(1)) dut0 (
        .clk(clk), .rst(rst), .en(en0), .src_sel(src0), .bus(if0),
        .lfsr_state(lfsr0), .sym_cnt(cnt0)
    );

    qam_mod_core #(.BITS_PER_AXIS(3), .PRBS_ORDER(4), .PRBS_SEED(1)) dut1 (
        .clk(clk), .rst(rst), .en(en1), .src_sel(src1), .bus(if1),
        .lfsr_state(lfsr1), .sym_cnt(cnt1)
    );

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Level from the word index: Gray-decoded if enabled, then 2v - (2^k - 1).
    function automatic int exp_level(input int v, input int k);
        int b;
        b = v;
        if (GRAY != 0) begin
            b = 0;
            for (int s = v; s != 0; s = s >> 1) b = b ^ s;
        end
        return 2 * b - ((1 << k) - 1);
    endfunction

    // LFSR contents after p advances: the next three bits of the m-sequence, oldest in the MSB.
    function automatic int prbs_state(input int p);
        return seq[p] * 4 + seq[p+1] * 2 + seq[p+2];
    endfunction

    // Reference model for dut0, evaluated between clock edges.
    initial begin : model_check
        bit last, free, avail, acc, exp_rdy;
        int b;
        seq[0] = 0; seq[1] = 0; seq[2] = 1;
        for (int i = 3; i < 4096; i++) seq[i] = seq[i-3] ^ seq[i-2];
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                m_bits.delete();
                m_pidx = 0; m_valid = 0; m_i = 0; m_q = 0; m_cnt = 0;
            end
            check("lfsr_state", 32'(lfsr0), prbs_state(m_pidx));
            check("sym_valid", 32'(if0.sym_valid), 32'(m_valid));
            check("sym_i", 32'($signed(if0.sym_i)), m_i);
            check("sym_q", 32'($signed(if0.sym_q)), m_q);
            check("sym_cnt", 32'(cnt0), m_cnt);
            exp_rdy = en0 && src0 && (m_bits.size() != 3 || !m_valid || if0.sym_ready);
            check("in_ready", 32'(if0.in_ready), 32'(exp_rdy));
            if (rst) begin
                last  = (m_bits.size() == 3);
                free  = !m_valid || if0.sym_ready;
                avail = src0 ? if0.in_valid : 1'b1;
                acc   = en0 && (!last || free) && avail;
                if (m_valid && if0.sym_ready) begin
                    m_valid = 0;
                    m_cnt   = (m_cnt + 1) % 65536;
                end
                if (acc) begin
                    if (src0) b = int'(if0.in_bit);
                    else begin
                        b = seq[m_pidx];
                        m_pidx++;
                    end
                    m_bits.push_back(b);
                    if (m_bits.size() == 4) begin
                        m_i = exp_level(m_bits[0] * 2 + m_bits[1], 2);
                        m_q = exp_level(m_bits[2] * 2 + m_bits[3], 2);
                        m_valid = 1;
                        m_bits.delete();
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        en0 = 1'b0;
        en1 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin : stimulus
        int bits4 [4];
        int gaps;
        rst = 1'b0; en0 = 1'b0; src0 = 1'b0; en1 = 1'b0; src1 = 1'b1;
        if0.in_bit = 1'b0; if0.in_valid = 1'b0; if0.sym_ready = 1'b0;
        if1.in_bit = 1'b0; if1.in_valid = 1'b0; if1.sym_ready = 1'b0;
        if (GRAY != 0) k3_lvl = '{-7, -5, -1, -3, 7, 5, 1, 3};
        else           k3_lvl = '{-7, -5, -3, -1, 1, 3, 5, 7};
        bits4 = '{1, 0, 1, 1};
        repeat (3) tick();

        // Free-run from reset release; PRBS bits 0010 111 0...
        rst = 1'b1; en0 = 1'b1; src0 = 1'b0; if0.sym_ready = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k <= 4) check($sformatf("first_valid_edge%0d", k), 32'(if0.sym_valid), (k == 4) ? 1 : 0);
            if (k == 4) begin
                check("free_sym1_i", 32'($signed(if0.sym_i)), -3);
                check("free_sym1_q", 32'($signed(if0.sym_q)), GRAY ? 3 : 1);
            end
            if (k == 7)  check("lfsr_period7", 32'(lfsr0), 1);
            if (k == 8) begin
                check("free_sym2_i", 32'($signed(if0.sym_i)), GRAY ? 1 : 3);
                check("free_sym2_q", 32'($signed(if0.sym_q)), GRAY ? 3 : 1);
                check("free_cnt_edge8", 32'(cnt0), 1);
            end
            if (k == 12) check("free_cnt_edge12", 32'(cnt0), 2);
            if (k == 14) check("lfsr_period14", 32'(lfsr0), 1);
        end

        // External bits 1,0,1,1.
        do_reset();
        en0 = 1'b1; src0 = 1'b1; if0.in_valid = 1'b1; if0.sym_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if0.in_bit = bits4[i][0];
            tick();
        end
        check("ext_valid", 32'(if0.sym_valid), 1);
        check("ext_sym_i", 32'($signed(if0.sym_i)), GRAY ? 3 : 1);
        check("ext_sym_q", 32'($signed(if0.sym_q)), GRAY ? 1 : 3);

        // Backpressure: 3 bits then stall, part of it in external mode.
        do_reset();
        en0 = 1'b1; src0 = 1'b0; if0.in_valid = 1'b0; if0.sym_ready = 1'b1;
        repeat (4) tick();
        if0.sym_ready = 1'b0;
        repeat (3) tick();
        src0 = 1'b1; if0.in_valid = 1'b1; if0.in_bit = 1'b1;
        repeat (7) tick();
        check("stall_held_i", 32'($signed(if0.sym_i)), -3);
        check("stall_valid", 32'(if0.sym_valid), 1);
        check("stall_lfsr", 32'(lfsr0), 1);
        src0 = 1'b0; if0.sym_ready = 1'b1;
        repeat (8) tick();

        // en drop after two bits and in_valid gaps; result must equal the gap-free symbol.
        do_reset();
        en0 = 1'b1; src0 = 1'b1; if0.sym_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                if0.in_valid = 1'b0; if0.in_bit = 1'($urandom);
                tick();
            end
            if0.in_valid = 1'b1; if0.in_bit = bits4[i][0];
            tick();
            if (i == 1) begin
                en0 = 1'b0; if0.in_bit = ~if0.in_bit;
                repeat (5) tick();
                en0 = 1'b1;
            end
        end
        if0.in_valid = 1'b0;
        check("gap_valid", 32'(if0.sym_valid), 1);
        check("gap_sym_i", 32'($signed(if0.sym_i)), GRAY ? 3 : 1);
        check("gap_sym_q", 32'($signed(if0.sym_q)), GRAY ? 1 : 3);

        // Reset with a symbol held and bit_cnt=2.
        do_reset();
        en0 = 1'b1; src0 = 1'b0; if0.sym_ready = 1'b0;
        repeat (6) tick();
        rst = 1'b0;
        #1;
        check("async_rst_valid", 32'(if0.sym_valid), 0);
        check("async_rst_lfsr", 32'(lfsr0), 1);
        check("async_rst_i", 32'($signed(if0.sym_i)), 0);
        tick();
        tick();
        rst = 1'b1; if0.sym_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("rerun_valid_edge%0d", k), 32'(if0.sym_valid), (k == 4) ? 1 : 0);
        end

        // Randomised traffic with source switching, gaps and backpressure.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            en0 = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 15) == 0) src0 = ~src0;
            if0.in_bit    = 1'($urandom);
            if0.in_valid  = ($urandom_range(0, 3) != 0);
            if0.sym_ready = ($urandom_range(0, 99) < 65);
            tick();
        end

        // K=3 sweep of all I words on the second core, Q word 000.
        do_reset();
        en0 = 1'b0;
        en1 = 1'b1; src1 = 1'b1; if1.in_valid = 1'b1; if1.sym_ready = 1'b1;
        for (int v = 0; v < 8; v++) begin
            for (int b = 0; b < 6; b++) begin
                if1.in_bit = (b < 3) ? 1'((v >> (2 - b)) & 1) : 1'b0;
                tick();
            end
            check($sformatf("k3_valid_w%0d", v), 32'(if1.sym_valid), 1);
            check($sformatf("k3_sym_i_w%0d", v), 32'($signed(if1.sym_i)), k3_lvl[v]);
            check($sformatf("k3_sym_q_w%0d", v), 32'($signed(if1.sym_q)), -7);
        end
        check("k3_cnt", 32'(cnt1), 7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
